// File: rtl/spi_boot_slave.sv
// spi_boot_slave: oversampled SPI boot/read-back slave driving a req/gnt/rvalid bus.
// Define SPI_BOOT_SLAVE_STATUS_EN to enable the 0x05 status command and err_o.
module spi_boot_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DUMMY_CYCLES = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk_i,
  input  logic                  spi_cs_i,
  input  logic                  spi_sdi0_i,
  output logic                  spi_sdo0_o,
  output logic                  spi_oe_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA,
    S_DUMMY, S_RDATA, S_STAT, S_IGNORE
  } state_e;

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic sck_prev_q, sck_prev_d;
  logic csn_prev_q, csn_prev_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] tx_cnt_q, tx_cnt_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic is_rd_q, is_rd_d;
  logic req_q, req_d;
  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic rd_out_q, rd_out_d;
  logic rd_keep_q, rd_keep_d;
  logic pf_valid_q, pf_valid_d;
  logic [31:0] pf_q, pf_d;
  logic err_q, err_d;

  logic sck_s, csn_s, sdi_s;
  logic sck_rise, sck_fall;
  logic csn_rise, csn_fall;
  logic [31:0] rx_next;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csn_rise = csn_s & ~csn_prev_q;
  assign csn_fall = ~csn_s & csn_prev_q;
  assign rx_next  = {rx_q[30:0], sdi_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_cnt_d   = tx_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    is_rd_d    = is_rd_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_out_d   = rd_out_q;
    rd_keep_d  = rd_keep_q;
    pf_valid_d = pf_valid_q;
    pf_d       = pf_q;
    err_d      = err_q;
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
    csn_sync_d = {csn_sync_q[SYNC_STAGES-2:0], spi_cs_i};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi0_i};
    sck_prev_d = sck_s;
    csn_prev_d = csn_s;

    if (req_q && mem_gnt_i) begin
      req_d  = 1'b0;
      we_d   = 1'b0;
      addr_d = addr_q + ADDR_WIDTH'(4);
      if (!we_q) rd_out_d = 1'b1;
    end
    // Late read data after an abort completes the bus cycle but is dropped.
    if (rd_out_q && mem_rvalid_i) begin
      rd_out_d = 1'b0;
      if (rd_keep_q) begin
        pf_valid_d = 1'b1;
        pf_d       = mem_rdata_i;
      end
    end

    if (csn_rise) begin
      state_d    = S_IDLE;
      rd_keep_d  = 1'b0;
      pf_valid_d = 1'b0;
      if (state_q == S_STAT) err_d = 1'b0;
    end else if (csn_fall) begin
      state_d = S_CMD;
      cnt_d   = '0;
    end else if (sck_rise) begin
      case (state_q)
        S_CMD: begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d = '0;
            case (rx_next[7:0])
              8'h02: begin
                state_d = S_ADDR;
                is_rd_d = 1'b0;
              end
              8'h0B: begin
                state_d = S_ADDR;
                is_rd_d = 1'b1;
              end
`ifdef SPI_BOOT_SLAVE_STATUS_EN
              8'h05: begin
                state_d  = S_STAT;
                tx_cnt_d = '0;
              end
`endif
              default: state_d = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd31) begin
            cnt_d    = '0;
            tx_cnt_d = '0;
            if (!is_rd_q) state_d = S_WDATA;
            else if (DUMMY_CYCLES == 0) state_d = S_RDATA;
            else state_d = S_DUMMY;
            if (req_q && !mem_gnt_i) begin
              err_d = 1'b1;
            end else begin
              addr_d = {rx_next[ADDR_WIDTH-1:2], 2'b00};
              if (is_rd_q) begin
                if (rd_out_d) begin
                  err_d = 1'b1;
                end else begin
                  req_d     = 1'b1;
                  we_d      = 1'b0;
                  rd_keep_d = 1'b1;
                end
              end
            end
          end
        end
        S_WDATA: begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd31) begin
            cnt_d = '0;
            if (req_q && !mem_gnt_i) begin
              err_d = 1'b1;
            end else begin
              req_d   = 1'b1;
              we_d    = 1'b1;
              wdata_d = rx_next;
            end
          end
        end
        S_DUMMY: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DUMMY_LAST) state_d = S_RDATA;
        end
        default: ;
      endcase
    end else if (sck_fall) begin
      case (state_q)
        S_RDATA: begin
          tx_cnt_d = tx_cnt_q + 5'd1;
          if (tx_cnt_q == 5'd0) begin
            if (pf_valid_d) begin
              tx_d       = pf_d;
              pf_valid_d = 1'b0;
              if (!req_d && !rd_out_d) begin
                req_d = 1'b1;
                we_d  = 1'b0;
              end
            end else begin
              tx_d  = '0;
              err_d = 1'b1;
            end
          end else begin
            tx_d = {tx_q[30:0], 1'b0};
          end
        end
        S_STAT: begin
          tx_cnt_d = tx_cnt_q + 5'd1;
          if (tx_cnt_q[2:0] == 3'd0) begin
            tx_d = {6'b0, err_q, req_q | rd_out_q, 24'b0};
          end else begin
            tx_d = {tx_q[30:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
`ifndef SPI_BOOT_SLAVE_STATUS_EN
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sck_sync_q <= '0;
      csn_sync_q <= '1;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      csn_prev_q <= 1'b1;
      cnt_q      <= '0;
      tx_cnt_q   <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      is_rd_q    <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_out_q   <= 1'b0;
      rd_keep_q  <= 1'b0;
      pf_valid_q <= 1'b0;
      pf_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_sync_q <= sck_sync_d;
      csn_sync_q <= csn_sync_d;
      sdi_sync_q <= sdi_sync_d;
      sck_prev_q <= sck_prev_d;
      csn_prev_q <= csn_prev_d;
      cnt_q      <= cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      is_rd_q    <= is_rd_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_out_q   <= rd_out_d;
      rd_keep_q  <= rd_keep_d;
      pf_valid_q <= pf_valid_d;
      pf_q       <= pf_d;
      err_q      <= err_d;
    end
  end

  assign spi_oe_o    = (state_q == S_RDATA) | (state_q == S_STAT);
  assign spi_sdo0_o  = spi_oe_o & tx_q[31];
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != S_IDLE) | req_q | rd_out_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_spi_boot_slave.sv
// tb_spi_boot_slave: directed SPI write/read/status/abort checks.
// Bus responder logs every granted request; expectations are hand-computed.
module tb_spi_boot_slave;

`ifdef SPI_BOOT_SLAVE_STATUS_EN
  localparam logic EXP_ERR = 1'b1;
  localparam logic [15:0] EXP_STAT = 16'h0202;
  localparam logic EXP_STAT_OE = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
  localparam logic [15:0] EXP_STAT = 16'h0000;
  localparam logic EXP_STAT_OE = 1'b0;
`endif
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_clk_i = 1'b0;
  logic spi_cs_i = 1'b1;
  logic spi_sdi0_i = 1'b0;
  logic spi_sdo0_o, spi_oe_o;
  logic mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic mem_gnt_i = 1'b0;
  logic mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic busy_o, err_o;

  int ncmp = 0;
  int nfail = 0;

  logic gnt_en = 1'b1;
  int rv_delay = 2;
  int rv_cnt = 0;
  logic [31:0] rv_data = '0;
  logic [31:0] log_addr [0:31];
  logic log_we [0:31];
  logic [31:0] log_wd [0:31];
  int log_n = 0;
  int n0;
  logic [31:0] din, din2;

  spi_boot_slave dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_clk_i    (spi_clk_i),
    .spi_cs_i     (spi_cs_i),
    .spi_sdi0_i   (spi_sdi0_i),
    .spi_sdo0_o   (spi_sdo0_o),
    .spi_oe_o     (spi_oe_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h2000: return 32'hCAFE_F00D;
      32'h2004: return 32'h0BAD_C0DE;
      default:  return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  always @(negedge clk) begin
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = rv_data;
      end
    end
    if (rst_n && mem_req_o && gnt_en) begin
      mem_gnt_i = 1'b1;
      if (log_n < 32) begin
        log_addr[log_n] = mem_addr_o;
        log_we[log_n] = mem_we_o;
        log_wd[log_n] = mem_wdata_o;
      end
      log_n++;
      if (!mem_we_o) begin
        rv_cnt = rv_delay;
        rv_data = mem_model(mem_addr_o);
      end
    end
  end

  task automatic fail(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
    nfail++;
    $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic cs_low();
    @(posedge clk);
    #3;
    spi_cs_i = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    spi_cs_i = 1'b1;
  endtask

  task automatic xfer(input logic [31:0] dout, input int nbits,
                      output logic [31:0] dres);
    dres = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_sdi0_i = dout[i];
      #(HALF);
      spi_clk_i = 1'b1;
      dres = {dres[30:0], spi_sdo0_o};
      #(HALF);
      spi_clk_i = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy_o; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    ncmp++;
    if (mem_req_o !== 1'b0) fail("rst_req", mem_req_o, 0);
    ncmp++;
    if (busy_o !== 1'b0) fail("rst_busy", busy_o, 0);
    ncmp++;
    if (err_o !== 1'b0) fail("rst_err", err_o, 0);
    ncmp++;
    if (spi_oe_o !== 1'b0) fail("rst_oe", spi_oe_o, 0);
    ncmp++;
    if (mem_addr_o !== 32'h0) fail("rst_addr", mem_addr_o, 0);
    rst_n = 1'b1;

    cs_low();
    xfer(32'h02, 8, din);
    xfer(32'h0000_1004, 32, din);
    xfer(32'hDEAD_BEEF, 32, din);
    xfer(32'h1234_5678, 32, din);
    ncmp++;
    if (busy_o !== 1'b1) fail("wr_busy_hi", busy_o, 1);
    cs_high();
    repeat (5) @(posedge clk);
    #1;
    ncmp++;
    if (busy_o !== 1'b0) fail("wr_busy_lo", busy_o, 0);
    ncmp++;
    if (log_n != 2) fail("wr_count", log_n, 2);
    ncmp++;
    if (log_addr[0] !== 32'h0000_1004)
      fail("wr0_addr", log_addr[0], 32'h1004);
    ncmp++;
    if (log_we[0] !== 1'b1) fail("wr0_we", log_we[0], 1);
    ncmp++;
    if (log_wd[0] !== 32'hDEAD_BEEF)
      fail("wr0_data", log_wd[0], 32'hDEAD_BEEF);
    ncmp++;
    if (log_addr[1] !== 32'h0000_1008)
      fail("wr1_addr", log_addr[1], 32'h1008);
    ncmp++;
    if (log_we[1] !== 1'b1) fail("wr1_we", log_we[1], 1);
    ncmp++;
    if (log_wd[1] !== 32'h1234_5678)
      fail("wr1_data", log_wd[1], 32'h1234_5678);
    ncmp++;
    if (err_o !== 1'b0) fail("wr_err", err_o, 0);

    gnt_en = 1'b0;
    cs_low();
    xfer(32'h02, 8, din);
    xfer(32'h0000_3000, 32, din);
    xfer(32'h1111_1111, 32, din);
    xfer(32'h2222_2222, 32, din);
    cs_high();
    repeat (20) @(posedge clk);
    #1;
    ncmp++;
    if (mem_req_o !== 1'b1) fail("ovf_req_held", mem_req_o, 1);
    ncmp++;
    if (mem_addr_o !== 32'h0000_3000)
      fail("ovf_addr", mem_addr_o, 32'h3000);
    ncmp++;
    if (mem_wdata_o !== 32'h1111_1111)
      fail("ovf_wdata", mem_wdata_o, 32'h1111_1111);
    ncmp++;
    if (busy_o !== 1'b1) fail("ovf_busy", busy_o, 1);
    ncmp++;
    if (err_o !== EXP_ERR) fail("ovf_err", err_o, EXP_ERR);
    gnt_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ncmp++;
    if (log_n != 3) fail("ovf_count", log_n, 3);
    ncmp++;
    if (log_wd[2] !== 32'h1111_1111)
      fail("ovf_log_data", log_wd[2], 32'h1111_1111);
    ncmp++;
    if (mem_addr_o !== 32'h0000_3004)
      fail("ovf_next_addr", mem_addr_o, 32'h3004);
    ncmp++;
    if (busy_o !== 1'b0) fail("ovf_busy_lo", busy_o, 0);

    cs_low();
    xfer(32'h05, 8, din);
    xfer(32'h0, 16, din);
    ncmp++;
    if (spi_oe_o !== EXP_STAT_OE) fail("stat_oe", spi_oe_o, EXP_STAT_OE);
    ncmp++;
    if (din[15:0] !== EXP_STAT) fail("stat_byte", din[15:0], EXP_STAT);
    cs_high();
    repeat (5) @(posedge clk);
    #1;
    ncmp++;
    if (err_o !== 1'b0) fail("stat_err_clr", err_o, 0);

    n0 = log_n;
    rv_delay = 2;
    cs_low();
    xfer(32'h0B, 8, din);
    xfer(32'h0000_2000, 32, din);
    xfer(32'h0, 32, din);
    xfer(32'h0, 32, din);
    xfer(32'h0, 32, din2);
    ncmp++;
    if (spi_oe_o !== 1'b1) fail("rd_oe", spi_oe_o, 1);
    ncmp++;
    if (din !== 32'hCAFE_F00D) fail("rd_word0", din, 32'hCAFE_F00D);
    ncmp++;
    if (din2 !== 32'h0BAD_C0DE) fail("rd_word1", din2, 32'h0BAD_C0DE);
    cs_high();
    wait_idle(2000);
    ncmp++;
    if (busy_o !== 1'b0) fail("rd_idle", busy_o, 0);
    ncmp++;
    if (log_addr[n0] !== 32'h0000_2000)
      fail("rd_addr0", log_addr[n0], 32'h2000);
    ncmp++;
    if (log_we[n0] !== 1'b0) fail("rd_we0", log_we[n0], 0);
    ncmp++;
    if (log_addr[n0+1] !== 32'h0000_2004)
      fail("rd_addr1", log_addr[n0+1], 32'h2004);
    ncmp++;
    if (log_we[n0+1] !== 1'b0) fail("rd_we1", log_we[n0+1], 0);
    ncmp++;
    if (err_o !== 1'b0) fail("rd_err", err_o, 0);

    n0 = log_n;
    rv_delay = 700;
    cs_low();
    xfer(32'h0B, 8, din);
    xfer(32'h0000_2000, 32, din);
    xfer(32'h0, 32, din);
    xfer(32'h0, 32, din);
    ncmp++;
    if (din !== 32'h0) fail("ur_zeros", din, 0);
    ncmp++;
    if (err_o !== EXP_ERR) fail("ur_err", err_o, EXP_ERR);
    cs_high();
    wait_idle(3000);
    ncmp++;
    if (busy_o !== 1'b0) fail("ur_idle", busy_o, 0);
    ncmp++;
    if (log_addr[n0] !== 32'h0000_2000)
      fail("ur_addr", log_addr[n0], 32'h2000);
    rv_delay = 2;

    n0 = log_n;
    cs_low();
    xfer(32'h02, 8, din);
    xfer(32'h0000_4000, 32, din);
    xfer(32'h000A_BCDE, 20, din);
    spi_cs_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ncmp++;
    if (busy_o !== 1'b1) fail("ab_busy_2clk", busy_o, 1);
    @(posedge clk);
    #1;
    ncmp++;
    if (busy_o !== 1'b0) fail("ab_idle_3clk", busy_o, 0);
    repeat (10) @(posedge clk);
    #1;
    ncmp++;
    if (mem_req_o !== 1'b0) fail("ab_no_req", mem_req_o, 0);
    ncmp++;
    if (log_n != n0) fail("ab_count", log_n, n0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
